// File: rtl/multicycle_control_if.sv
// Memory handshake bundle between the multicycle control FSM and the
// instruction/data memories.
interface multicycle_control_if;
  // A request stays high until the cycle its ready is sampled high.
  // Ready is only meaningful while the matching request is high and is
  // ignored in every other cycle. dmem_we qualifies dmem_req.
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV64 subset core (add, sub, and, or,
// addi, ld, sd, beq), with a memory wait timeout and perf counters.
module multicycle_control #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 instr_zero,
  input  logic                 alu_zero,
  multicycle_control_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 alu_src,
  output logic [3:0]           alu_ctrl,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 halted,
  output logic                 illegal_instr,
  output logic                 bus_error,
  output logic [CNT_W-1:0]     instret,
  output logic [CNT_W-1:0]     cycles,
  output logic [2:0]           dbg_state
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB_ALU, S_WB_MEM, S_BRANCH, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              set_ill, set_berr, retire;

  logic       is_rtype, is_addi, is_ld, is_sd, is_beq;
  logic [3:0] dec_alu_ctrl;
  logic       dec_alu_src;

  // Instruction class and ALU setup, decoded straight from the held IR fields.
  always_comb begin
    is_rtype     = 1'b0;
    is_addi      = 1'b0;
    is_ld        = 1'b0;
    is_sd        = 1'b0;
    is_beq       = 1'b0;
    dec_alu_ctrl = ALU_ADD;
    dec_alu_src  = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct3)
          3'b000: begin
            is_rtype     = 1'b1;
            dec_alu_ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
          end
          3'b111: begin
            is_rtype     = 1'b1;
            dec_alu_ctrl = ALU_AND;
          end
          3'b110: begin
            is_rtype     = 1'b1;
            dec_alu_ctrl = ALU_OR;
          end
          default: ;
        endcase
      end
      OP_I: begin
        if (funct3 == 3'b000) begin
          is_addi     = 1'b1;
          dec_alu_src = 1'b1;
        end
      end
      OP_LD: begin
        if (funct3 == 3'b011) begin
          is_ld       = 1'b1;
          dec_alu_src = 1'b1;
        end
      end
      OP_SD: begin
        if (funct3 == 3'b011) begin
          is_sd       = 1'b1;
          dec_alu_src = 1'b1;
        end
      end
      OP_BR: begin
        if (funct3 == 3'b000) begin
          is_beq       = 1'b1;
          dec_alu_ctrl = ALU_SUB;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    set_ill      = 1'b0;
    set_berr     = 1'b0;
    retire       = 1'b0;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src      = 1'b0;
    alu_ctrl     = ALU_ADD;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          wait_d   = '0;
          state_d  = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          set_berr = 1'b1;
          wait_d   = '0;
          state_d  = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (instr_zero) begin
          state_d = S_HALT;
        end else if (is_rtype || is_addi || is_ld || is_sd) begin
          state_d = S_EXEC;
        end else if (is_beq) begin
          state_d = S_BRANCH;
        end else begin
          set_ill = 1'b1;
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        alu_src  = dec_alu_src;
        alu_ctrl = dec_alu_ctrl;
        state_d  = (is_ld || is_sd) ? S_MEM : S_WB_ALU;
      end
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = is_sd;
        alu_src      = dec_alu_src;
        alu_ctrl     = dec_alu_ctrl;
        if (mem.dmem_ready) begin
          wait_d  = '0;
          retire  = is_sd;
          state_d = is_sd ? S_FETCH : S_WB_MEM;
        end else if (wait_q == WAIT_LAST) begin
          set_berr = 1'b1;
          wait_d   = '0;
          state_d  = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB_ALU: begin
        alu_src   = dec_alu_src;
        alu_ctrl  = dec_alu_ctrl;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_WB_MEM: begin
        alu_src    = dec_alu_src;
        alu_ctrl   = dec_alu_ctrl;
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src  = dec_alu_src;
        alu_ctrl = dec_alu_ctrl;
        pc_write = alu_zero;
        pc_src   = alu_zero;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: ;
    endcase
    // Reset state is FETCH, so strobes are masked to drop any request at once.
    if (!reset) begin
      mem.imem_req = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_FETCH;
      wait_q        <= '0;
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
      instret       <= '0;
      cycles        <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (set_ill)  illegal_instr <= 1'b1;
      if (set_berr) bus_error     <= 1'b1;
      if (retire)   instret <= instret + CNT_W'(1);
      if (state_q != S_HALT) cycles <= cycles + CNT_W'(1);
    end
  end

  assign halted    = (state_q == S_HALT);
  assign dbg_state = state_q;

endmodule
